// File: rtl/demux2_array3_array2_reg.sv
// demux2_array3_array2_reg: routes a 3x2-bit word to one of two registered output slots with ready/valid handshakes and per-destination transfer counters.
module demux2_array3_array2_reg (
   input  logic       CLK,
   input  logic       ASYNCRESET,
   input  logic [1:0] I [3],
   input  logic       S,
   input  logic       I_valid,
   output logic       I_ready,
   output logic [1:0] O0 [3],
   output logic       O0_valid,
   input  logic       O0_ready,
   output logic [1:0] O1 [3],
   output logic       O1_valid,
   input  logic       O1_ready,
   output logic [7:0] CNT0,
   output logic [7:0] CNT1
);
   logic [5:0] d0, d1, i_flat;
   logic acc, ld0, ld1, tx0, tx1;
   assign i_flat = {I[2], I[1], I[0]};
   assign I_ready = S ? (!O1_valid || O1_ready) : (!O0_valid || O0_ready);
   assign acc = I_valid && I_ready;
   assign ld0 = acc && !S;
   assign ld1 = acc && S;
   assign tx0 = O0_valid && O0_ready;
   assign tx1 = O1_valid && O1_ready;
   for (genvar k = 0; k < 3; k++) begin : g_unflat
      assign O0[k] = d0[2*k+1:2*k];
      assign O1[k] = d1[2*k+1:2*k];
   end
   // a reload on the same edge as a drain keeps the slot valid
   always_ff @(posedge CLK or posedge ASYNCRESET)
      if (ASYNCRESET) begin
         d0 <= '0;
         d1 <= '0;
         O0_valid <= 1'b0;
         O1_valid <= 1'b0;
         CNT0 <= '0;
         CNT1 <= '0;
      end else begin
         if (ld0) d0 <= i_flat;
         if (ld1) d1 <= i_flat;
         O0_valid <= ld0 || (O0_valid && !tx0);
         O1_valid <= ld1 || (O1_valid && !tx1);
         if (tx0) CNT0 <= CNT0 + 8'd1;
         if (tx1) CNT1 <= CNT1 + 8'd1;
      end
endmodule
